// File: rtl/sdiv_pkg.sv
// Shared types and helpers for the pipelined restoring divider.
package sdiv_pkg;

    // Upper bound on any vector passed through the helper functions below.
    localparam int SDIV_MAXW = 128;

    typedef struct packed {
        logic dbz;
        logic ovf;
    } sdiv_status_t;

    // Number of set bits among the low 'width' bits of a register-placement mask.
    function automatic int popcount_mask(input logic [SDIV_MAXW-1:0] mask, input int width);
        int n;
        n = 0;
        for (int i = 0; i < SDIV_MAXW; i++) begin
            if (i < width && mask[i]) begin
                n++;
            end
        end
        return n;
    endfunction

    // Mask with a register at every one of the 'maskw' boundaries.
    function automatic logic [SDIV_MAXW-1:0] default_mask(input int maskw);
        logic [SDIV_MAXW-1:0] m;
        m = '0;
        for (int i = 0; i < SDIV_MAXW; i++) begin
            if (i < maskw) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    // Two's-complement negate when 'neg' is set. Callers zero-extend into and
    // truncate out of SDIV_MAXW; the low bits of the result are exact.
    function automatic logic [SDIV_MAXW-1:0] cond_negate(input logic [SDIV_MAXW-1:0] x,
                                                         input logic neg);
        return neg ? ((~x) + SDIV_MAXW'(1)) : x;
    endfunction

    // Sign of a 'width'-bit value; always 0 for unsigned operation.
    function automatic logic sign_of(input logic [SDIV_MAXW-1:0] x, input int width,
                                     input logic is_signed);
        return is_signed && x[width-1];
    endfunction

endpackage

// File: rtl/sdiv_cell.sv
// One radix-2 restoring step: shift in a dividend bit, subtract the divisor
// if it fits, and report the quotient bit.
module sdiv_cell
    import sdiv_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH:0]   rem_i,
    input  logic                 d_i,
    input  logic [DATAWIDTH-1:0] b_i,
    output logic [DATAWIDTH:0]   rem_o,
    output logic                 q_o
);

    logic [DATAWIDTH:0] trial;
    logic [DATAWIDTH:0] divisor;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero and dropping it before the shift loses nothing.
    always_comb begin
        trial   = {DATAWIDTH'(rem_i), d_i};
        divisor = {1'b0, b_i};
        q_o     = (trial >= divisor);
        rem_o   = q_o ? (trial - divisor) : trial;
    end

endmodule

// File: rtl/pipelined_sdivider.sv
// Pipelined restoring array divider with optional signed operands, fractional
// quotient bits, mask-selected register boundaries and a valid/ready handshake
// that stalls the whole pipe when the consumer is not ready.
module pipelined_sdivider
    import sdiv_pkg::*;
#(
    parameter  int DATAWIDTH = 8,
    parameter  int FRAC_BITS = 0,
    parameter  int SIGNED    = 0,
    localparam int NCELLS    = DATAWIDTH + FRAC_BITS,
    localparam int MASKW     = NCELLS + 1,
    parameter  logic [MASKW-1:0] STAGE_MASK = MASKW'(default_mask(MASKW)),
    parameter  int TAG_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [DATAWIDTH-1:0] A,
    input  logic [DATAWIDTH-1:0] B,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [NCELLS-1:0]    Q_out,
    output logic [DATAWIDTH-1:0] R_out,
    output logic [TAG_W-1:0]     o_tag,
    output logic                 o_dbz,
    output logic                 o_ovf
);

    localparam int LAT = popcount_mask(SDIV_MAXW'(STAGE_MASK), MASKW);
    localparam logic [NCELLS-1:0] Q_MAXPOS = {1'b0, {(NCELLS-1){1'b1}}};
    localparam logic [NCELLS-1:0] Q_MINNEG = {1'b1, {(NCELLS-1){1'b0}}};

    logic stall;

    // Operand conditioning: magnitudes feed the cells, signs ride alongside.
    logic                 a_neg;
    logic                 b_neg;
    logic [DATAWIDTH-1:0] a_mag;
    logic [DATAWIDTH-1:0] b_mag;

    assign a_neg = sign_of(SDIV_MAXW'(A), DATAWIDTH, SIGNED != 0);
    assign b_neg = sign_of(SDIV_MAXW'(B), DATAWIDTH, SIGNED != 0);
    // |-2^(N-1)| wraps to the N-bit unsigned pattern 2^(N-1), which is the
    // correct magnitude for the unsigned cells.
    assign a_mag = DATAWIDTH'(cond_negate(SDIV_MAXW'(A), a_neg));
    assign b_mag = DATAWIDTH'(cond_negate(SDIV_MAXW'(B), b_neg));

    // Slot k sits in front of cell k; slot NCELLS is the output boundary.
    for (genvar k = 0; k <= NCELLS; k++) begin : g_slot
        logic                 v_d,   v_q;
        logic [DATAWIDTH:0]   rem_d, rem_q;
        logic [NCELLS-1:0]    quo_d, quo_q;
        logic [NCELLS-1:0]    dvd_d, dvd_q;
        logic [DATAWIDTH-1:0] dvs_d, dvs_q;
        logic                 an_d,  an_q;
        logic                 bn_d,  bn_q;
        logic                 dbz_d, dbz_q;
        logic [TAG_W-1:0]     tag_d, tag_q;

        if (k == 0) begin : g_src
            assign v_d   = i_valid;
            assign rem_d = '0;
            assign quo_d = '0;
            assign dvd_d = NCELLS'(a_mag) << FRAC_BITS;
            assign dvs_d = b_mag;
            assign an_d  = a_neg;
            assign bn_d  = b_neg;
            assign dbz_d = (B == '0);
            assign tag_d = i_tag;
        end else begin : g_src
            assign v_d   = g_slot[k-1].v_q;
            assign rem_d = g_slot[k-1].g_cell.rem_nx;
            // Quotient bits are shifted in LSB-first so the first cell ends at the MSB.
            assign quo_d = NCELLS'({g_slot[k-1].quo_q, g_slot[k-1].g_cell.q_nx});
            assign dvd_d = g_slot[k-1].dvd_q;
            assign dvs_d = g_slot[k-1].dvs_q;
            assign an_d  = g_slot[k-1].an_q;
            assign bn_d  = g_slot[k-1].bn_q;
            assign dbz_d = g_slot[k-1].dbz_q;
            assign tag_d = g_slot[k-1].tag_q;
        end

        if (STAGE_MASK[k]) begin : g_reg
            // Boundary register: cleared on reset, frozen while the output stalls.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    rem_q <= '0;
                    quo_q <= '0;
                    dvd_q <= '0;
                    dvs_q <= '0;
                    an_q  <= 1'b0;
                    bn_q  <= 1'b0;
                    dbz_q <= 1'b0;
                    tag_q <= '0;
                end else if (!stall) begin
                    v_q   <= v_d;
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    dvd_q <= dvd_d;
                    dvs_q <= dvs_d;
                    an_q  <= an_d;
                    bn_q  <= bn_d;
                    dbz_q <= dbz_d;
                    tag_q <= tag_d;
                end
            end
        end else begin : g_wire
            assign v_q   = v_d;
            assign rem_q = rem_d;
            assign quo_q = quo_d;
            assign dvd_q = dvd_d;
            assign dvs_q = dvs_d;
            assign an_q  = an_d;
            assign bn_q  = bn_d;
            assign dbz_q = dbz_d;
            assign tag_q = tag_d;
        end

        if (k < NCELLS) begin : g_cell
            logic [DATAWIDTH:0] rem_nx;
            logic               q_nx;

            sdiv_cell #(
                .DATAWIDTH(DATAWIDTH)
            ) u_cell (
                .rem_i(rem_q),
                .d_i  (dvd_q[NCELLS-1-k]),
                .b_i  (dvs_q),
                .rem_o(rem_nx),
                .q_o  (q_nx)
            );
        end
    end

    // The divisor is not needed past the last cell.
    logic unused_tail_dvs;
    assign unused_tail_dvs = ^g_slot[NCELLS].dvs_q;

    logic [NCELLS-1:0]    q_mag;
    logic [NCELLS-1:0]    q_res;
    logic [DATAWIDTH-1:0] r_mag;
    logic [DATAWIDTH-1:0] r_res;
    logic [DATAWIDTH-1:0] a_abs;
    logic                 q_neg;
    sdiv_status_t         st;

    // Result fix-up: sign restoration, divide-by-zero and overflow substitution.
    always_comb begin
        q_mag = g_slot[NCELLS].quo_q;
        r_mag = DATAWIDTH'(g_slot[NCELLS].rem_q);
        a_abs = DATAWIDTH'(g_slot[NCELLS].dvd_q >> FRAC_BITS);
        q_neg = g_slot[NCELLS].an_q ^ g_slot[NCELLS].bn_q;
        st    = '0;
        q_res = q_mag;
        r_res = r_mag;
        if (SIGNED != 0) begin
            if (g_slot[NCELLS].dbz_q) begin
                st.dbz = 1'b1;
                q_res  = g_slot[NCELLS].an_q ? Q_MINNEG : Q_MAXPOS;
                r_res  = DATAWIDTH'(cond_negate(SDIV_MAXW'(a_abs), g_slot[NCELLS].an_q));
            end else if (q_neg ? (q_mag > Q_MINNEG) : (q_mag >= Q_MINNEG)) begin
                st.ovf = 1'b1;
                q_res  = Q_MAXPOS;
                r_res  = '0;
            end else begin
                q_res = NCELLS'(cond_negate(SDIV_MAXW'(q_mag), q_neg));
                r_res = DATAWIDTH'(cond_negate(SDIV_MAXW'(r_mag), g_slot[NCELLS].an_q));
            end
        end else if (g_slot[NCELLS].dbz_q) begin
            st.dbz = 1'b1;
            q_res  = '1;
            r_res  = a_abs;
        end
    end

    assign o_valid = g_slot[NCELLS].v_q;
    assign stall   = o_valid && !o_ready;
    // With no registers at all the block is a wire from input to output, so
    // readiness is simply the consumer's readiness.
    assign i_ready = (LAT == 0) ? o_ready : !stall;

    assign Q_out = o_valid ? q_res : '0;
    assign R_out = o_valid ? r_res : '0;
    assign o_tag = o_valid ? g_slot[NCELLS].tag_q : '0;
    assign o_dbz = o_valid && st.dbz;
    assign o_ovf = o_valid && st.ovf;

endmodule

// File: tb/tb_pipelined_sdivider.sv
// Scoreboard bench: three divider configurations (unsigned, signed, fractional
// with sparse registers) fed from a shared operand bus.
module tb_pipelined_sdivider;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  iv;
    logic [2:0]  ir;
    logic [2:0]  ov;
    logic [7:0]  a_in, b_in;
    logic [3:0]  tag_in;
    logic        o_rdy;
    logic        bp_en;

    logic [7:0]  q0, q1;
    logic [11:0] q2;
    logic [7:0]  r0, r1, r2;
    logic [3:0]  t0, t1, t2;
    logic [2:0]  dbz, ovf;

    logic [15:0] qv [3];
    logic [7:0]  rv [3];
    logic [3:0]  tv [3];
    int          lat [3] = '{9, 9, 3};

    assign qv[0] = {8'h00, q0};
    assign qv[1] = {8'h00, q1};
    assign qv[2] = {4'h0, q2};
    assign rv[0] = r0;
    assign rv[1] = r1;
    assign rv[2] = r2;
    assign tv[0] = t0;
    assign tv[1] = t1;
    assign tv[2] = t2;

    pipelined_sdivider #(.DATAWIDTH(8), .FRAC_BITS(0), .SIGNED(0),
                         .STAGE_MASK(9'h1FF), .TAG_W(4)) u_dut0 (
        .clk(clk), .rst(rst), .i_valid(iv[0]), .i_ready(ir[0]), .A(a_in), .B(b_in),
        .i_tag(tag_in), .o_valid(ov[0]), .o_ready(o_rdy), .Q_out(q0), .R_out(r0),
        .o_tag(t0), .o_dbz(dbz[0]), .o_ovf(ovf[0]));

    pipelined_sdivider #(.DATAWIDTH(8), .FRAC_BITS(0), .SIGNED(1),
                         .STAGE_MASK(9'h1FF), .TAG_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(iv[1]), .i_ready(ir[1]), .A(a_in), .B(b_in),
        .i_tag(tag_in), .o_valid(ov[1]), .o_ready(o_rdy), .Q_out(q1), .R_out(r1),
        .o_tag(t1), .o_dbz(dbz[1]), .o_ovf(ovf[1]));

    pipelined_sdivider #(.DATAWIDTH(8), .FRAC_BITS(4), .SIGNED(0),
                         .STAGE_MASK(13'b1000000001001), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .i_valid(iv[2]), .i_ready(ir[2]), .A(a_in), .B(b_in),
        .i_tag(tag_in), .o_valid(ov[2]), .o_ready(o_rdy), .Q_out(q2), .R_out(r2),
        .o_tag(t2), .o_dbz(dbz[2]), .o_ovf(ovf[2]));

    typedef struct {
        int         dut;
        logic [15:0] q;
        logic [7:0]  r;
        logic [3:0]  tag;
        logic        dz;
        logic        of;
        int          due;
    } exp_t;

    exp_t sb [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Drive one operand pair into DUT d once it is ready and record the expectation.
    task automatic issue(input int d, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] eq, input logic [7:0] er,
                         input logic ed, input logic eo, input bit timed);
        exp_t e;
        int   waited;
        logic [3:0] t;
        t = 4'($urandom_range(0, 15));
        a_in = a;
        b_in = b;
        tag_in = t;
        iv[d] = 1'b1;
        #1;
        waited = 0;
        while (!ir[d] && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ir[d]) begin
            n_chk++;
            n_fail++;
            $display("FAIL issue_timeout dut%0d: i_ready stayed 0, required 1", d);
            @(negedge clk);
            iv[d] = 1'b0;
            return;
        end
        e.dut = d;
        e.q   = eq;
        e.r   = er;
        e.tag = t;
        e.dz  = ed;
        e.of  = eo;
        e.due = timed ? cyc + lat[d] : -1;
        sb.push_back(e);
        @(negedge clk);
        iv[d] = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() > 0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    // Consumer readiness: random under backpressure, otherwise always ready.
    initial begin
        o_rdy = 1'b1;
        forever begin
            @(negedge clk);
            o_rdy = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshake rule, idle outputs, and in-order result checking.
    initial begin
        exp_t e;
        int   idx;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                for (int d = 0; d < 3; d++) begin
                    chk($sformatf("ready_rule%0d", d), 32'(ir[d]), 32'(!(ov[d] && !o_rdy)));
                    if (!ov[d]) begin
                        chk($sformatf("idle_zero%0d", d),
                            32'({qv[d], rv[d], tv[d], dbz[d], ovf[d]}), 32'd0);
                    end else if (o_rdy) begin
                        idx = -1;
                        for (int i = 0; i < sb.size(); i++) begin
                            if (idx < 0 && sb[i].dut == d) idx = i;
                        end
                        if (idx < 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_out%0d: got Q=%0h with no pending op", d, qv[d]);
                        end else begin
                            e = sb[idx];
                            sb.delete(idx);
                            chk($sformatf("q%0d", d),   32'(qv[d]),  32'(e.q));
                            chk($sformatf("r%0d", d),   32'(rv[d]),  32'(e.r));
                            chk($sformatf("tag%0d", d), 32'(tv[d]),  32'(e.tag));
                            chk($sformatf("dbz%0d", d), 32'(dbz[d]), 32'(e.dz));
                            chk($sformatf("ovf%0d", d), 32'(ovf[d]), 32'(e.of));
                            if (e.due >= 0) chk($sformatf("latency%0d", d), 32'(cyc), 32'(e.due));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b;
        rst = 1'b1;
        iv = '0;
        a_in = '0;
        b_in = '0;
        tag_in = '0;
        bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d), 32'(ov[d]), 32'd0);
            chk($sformatf("rst_ready%0d", d), 32'(ir[d]), 32'd1);
            chk($sformatf("rst_outs%0d", d), 32'({qv[d], rv[d], tv[d], dbz[d], ovf[d]}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Unsigned 8-bit, full mask.
        issue(0, 8'd200, 8'd7,   16'd28,  8'd4,   1'b0, 1'b0, 1'b1);
        issue(0, 8'd13,  8'd0,   16'hFF,  8'd13,  1'b1, 1'b0, 1'b1);
        issue(0, 8'd255, 8'd1,   16'd255, 8'd0,   1'b0, 1'b0, 1'b1);
        issue(0, 8'd7,   8'd200, 16'd0,   8'd7,   1'b0, 1'b0, 1'b1);
        issue(0, 8'd255, 8'd255, 16'd1,   8'd0,   1'b0, 1'b0, 1'b1);
        issue(0, 8'd0,   8'd5,   16'd0,   8'd0,   1'b0, 1'b0, 1'b1);
        issue(0, 8'd250, 8'd16,  16'd15,  8'd10,  1'b0, 1'b0, 1'b1);

        // Signed 8-bit, full mask.
        issue(1, 8'hF9, 8'h02, 16'hFD, 8'hFF, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h07, 8'hFE, 16'hFD, 8'h01, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h80, 8'hFF, 16'h7F, 8'h00, 1'b0, 1'b1, 1'b1);
        issue(1, 8'hFB, 8'h00, 16'h80, 8'hFB, 1'b1, 1'b0, 1'b1);
        issue(1, 8'h05, 8'h00, 16'h7F, 8'h05, 1'b1, 1'b0, 1'b1);
        issue(1, 8'h00, 8'h00, 16'h7F, 8'h00, 1'b1, 1'b0, 1'b1);
        issue(1, 8'hF9, 8'hFE, 16'h03, 8'hFF, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h64, 8'h07, 16'h0E, 8'h02, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h80, 8'h01, 16'h80, 8'h00, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h7F, 8'h80, 16'h00, 8'h7F, 1'b0, 1'b0, 1'b1);
        issue(1, 8'h80, 8'h80, 16'h01, 8'h00, 1'b0, 1'b0, 1'b1);

        // Unsigned with 4 fractional bits, registers at boundaries 0, 3 and 12.
        issue(2, 8'd1,   8'd3,   16'h005, 8'd1,  1'b0, 1'b0, 1'b1);
        issue(2, 8'd200, 8'd7,   16'h1C9, 8'd1,  1'b0, 1'b0, 1'b1);
        issue(2, 8'd255, 8'd1,   16'hFF0, 8'd0,  1'b0, 1'b0, 1'b1);
        issue(2, 8'd13,  8'd0,   16'hFFF, 8'd13, 1'b1, 1'b0, 1'b1);
        issue(2, 8'd1,   8'd255, 16'h000, 8'd16, 1'b0, 1'b0, 1'b1);
        issue(2, 8'd10,  8'd4,   16'h028, 8'd0,  1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure stream on the unsigned divider.
        bp_en = 1'b1;
        for (int n = 0; n < 20; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if (b == 8'd0)
                issue(0, a, b, 16'hFF, a, 1'b1, 1'b0, 1'b0);
            else
                issue(0, a, b, 16'(a / b), 8'(a % b), 1'b0, 1'b0, 1'b0);
        end
        bp_en = 1'b0;
        drain();

        // Reset with five operations in flight.
        for (int n = 0; n < 5; n++) begin
            issue(0, 8'(50 + n), 8'd3, 16'(8'(50 + n) / 8'd3), 8'(8'(50 + n) % 8'd3),
                  1'b0, 1'b0, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", 32'(ov[0]), 32'd0);
        chk("midrst_ready", 32'(ir[0]), 32'd1);
        chk("midrst_outs", 32'({qv[0], rv[0], tv[0], dbz[0], ovf[0]}), 32'd0);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].dut == 0) sb.delete(i);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(0, 8'd200, 8'd7, 16'd28, 8'd4, 1'b0, 1'b0, 1'b1);
        drain();
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
